// File: rtl/hv_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// hv_transaction_ctrl
//
// Sequences one transaction with the HV power supply over the HV UART block.
// A command frame (STX 0x02 .. CR 0x0D) is pulled from the cmd path and
// streamed into the HV tx FIFO. The supply's reply frame (STX .. CR) is then
// collected from the HV rx side and forwarded upstream. Completion or failure
// is reported with a one-cycle hv_end pulse; failures leave a sticky err flag
// and an error code until the next transaction starts.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   soft_rst       synchronous abort back to IDLE, highest priority
//   hv_start       one-cycle pulse that starts a transaction from IDLE
//   cmd_data/valid command byte stream; cmd_ready accepts it (SEND only)
//   hv_wr_en/data  write port of the HV tx FIFO (one cycle after the beat)
//   hv_rd_data/valid  byte strobe received from the supply
//   up_data/valid  reply bytes forwarded upstream (one cycle after receipt)
//   hv_busy        bus owned, SEND through DONE/ERROR
//   hv_end         one-cycle pulse at the end of a transaction
//   err, err_code  sticky failure flag, 0 none / 1 bad STX / 2 overflow /
//                  3 timeout
//   rsp_len        length of the last successful reply, STX..CR inclusive
// -----------------------------------------------------------------------------
module hv_transaction_ctrl #(
    parameter int MAX_FRAME      = 32,
    parameter int CNT_W          = 6,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int TO_W           = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst,
    input  logic             hv_start,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             hv_wr_en,
    output logic [7:0]       hv_wr_data,
    input  logic [7:0]       hv_rd_data,
    input  logic             hv_rd_valid,
    output logic [7:0]       up_data,
    output logic             up_valid,
    output logic             hv_busy,
    output logic             hv_end,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] rsp_len
);

    localparam logic [7:0] BYTE_STX = 8'h02;
    localparam logic [7:0] BYTE_CR  = 8'h0D;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_BAD_STX = 2'd1;
    localparam logic [1:0] CODE_OVF     = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Count value held while the last permitted byte of a frame arrives.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAME - 1);

    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_RECV     = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [TO_W-1:0]  timer_r;
    logic [TO_W-1:0]  timer_nxt_s;

    logic             hv_wr_en_r;
    logic             hv_wr_en_nxt_s;
    logic [7:0]       hv_wr_data_r;
    logic [7:0]       hv_wr_data_nxt_s;
    logic             up_valid_r;
    logic             up_valid_nxt_s;
    logic [7:0]       up_data_r;
    logic [7:0]       up_data_nxt_s;
    logic             hv_end_r;
    logic             hv_end_nxt_s;
    logic             err_r;
    logic             err_nxt_s;
    logic [1:0]       err_code_r;
    logic [1:0]       err_code_nxt_s;
    logic [CNT_W-1:0] rsp_len_r;
    logic [CNT_W-1:0] rsp_len_nxt_s;

    logic             cmd_ready_s;
    logic             cmd_beat_s;
    logic             timed_out_s;

    assign cmd_ready_s = (state_r == ST_SEND);
    assign cmd_beat_s  = cmd_valid & cmd_ready_s;
    // Compared with >= so a timer that has run onto the limit while a byte
    // was being handled still expires on the next idle cycle.
    assign timed_out_s = (timer_r >= TO_LAST);

    // Next-state and next-value decode for the whole transaction sequence.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        timer_nxt_s      = timer_r;
        hv_wr_en_nxt_s   = 1'b0;
        hv_wr_data_nxt_s = hv_wr_data_r;
        up_valid_nxt_s   = 1'b0;
        up_data_nxt_s    = up_data_r;
        hv_end_nxt_s     = 1'b0;
        err_nxt_s        = err_r;
        err_code_nxt_s   = err_code_r;
        rsp_len_nxt_s    = rsp_len_r;

        if (soft_rst) begin
            // Abort: no hv_end, all status cleared, pending start dropped.
            state_nxt_s    = ST_IDLE;
            cnt_nxt_s      = CNT_ZERO;
            timer_nxt_s    = TO_ZERO;
            err_nxt_s      = 1'b0;
            err_code_nxt_s = CODE_NONE;
            rsp_len_nxt_s  = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hv_start) begin
                        state_nxt_s    = ST_SEND;
                        cnt_nxt_s      = CNT_ZERO;
                        timer_nxt_s    = TO_ZERO;
                        err_nxt_s      = 1'b0;
                        err_code_nxt_s = CODE_NONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end

                ST_SEND: begin
                    if (cmd_beat_s) begin
                        if ((cnt_r == CNT_ZERO) && (cmd_data != BYTE_STX)) begin
                            // Bad frame start: the byte is not written.
                            state_nxt_s    = ST_ERROR;
                            err_nxt_s      = 1'b1;
                            err_code_nxt_s = CODE_BAD_STX;
                        end else begin
                            hv_wr_en_nxt_s   = 1'b1;
                            hv_wr_data_nxt_s = cmd_data;
                            cnt_nxt_s        = cnt_r + CNT_ONE;
                            if (cmd_data == BYTE_CR) begin
                                state_nxt_s = ST_WAIT_RSP;
                                timer_nxt_s = TO_ZERO;
                            end else if (cnt_r == CNT_LAST) begin
                                state_nxt_s    = ST_ERROR;
                                err_nxt_s      = 1'b1;
                                err_code_nxt_s = CODE_OVF;
                            end else begin
                                state_nxt_s = ST_SEND;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_SEND;
                    end
                end

                ST_WAIT_RSP: begin
                    if (hv_rd_valid) begin
                        // A received byte takes priority over an expiring timer.
                        if (hv_rd_data == BYTE_STX) begin
                            state_nxt_s    = ST_RECV;
                            cnt_nxt_s      = CNT_ONE;
                            timer_nxt_s    = TO_ZERO;
                            up_valid_nxt_s = 1'b1;
                            up_data_nxt_s  = hv_rd_data;
                        end else if (!timed_out_s) begin
                            timer_nxt_s = timer_r + TO_ONE;
                        end else begin
                            timer_nxt_s = timer_r;
                        end
                    end else if (timed_out_s) begin
                        state_nxt_s    = ST_ERROR;
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = CODE_TIMEOUT;
                    end else begin
                        timer_nxt_s = timer_r + TO_ONE;
                    end
                end

                ST_RECV: begin
                    if (hv_rd_valid) begin
                        up_valid_nxt_s = 1'b1;
                        up_data_nxt_s  = hv_rd_data;
                        cnt_nxt_s      = cnt_r + CNT_ONE;
                        timer_nxt_s    = TO_ZERO;
                        if (hv_rd_data == BYTE_CR) begin
                            state_nxt_s   = ST_DONE;
                            rsp_len_nxt_s = cnt_r + CNT_ONE;
                        end else if (cnt_r == CNT_LAST) begin
                            state_nxt_s    = ST_ERROR;
                            err_nxt_s      = 1'b1;
                            err_code_nxt_s = CODE_OVF;
                        end else begin
                            state_nxt_s = ST_RECV;
                        end
                    end else if (timed_out_s) begin
                        state_nxt_s    = ST_ERROR;
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = CODE_TIMEOUT;
                    end else begin
                        timer_nxt_s = timer_r + TO_ONE;
                    end
                end

                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end

                ST_ERROR: begin
                    state_nxt_s = ST_IDLE;
                end

                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase

            // hv_end is registered, so it is high during the DONE/ERROR cycle.
            hv_end_nxt_s = (state_nxt_s == ST_DONE) || (state_nxt_s == ST_ERROR);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, status and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= CNT_ZERO;
            timer_r      <= TO_ZERO;
            hv_wr_en_r   <= 1'b0;
            hv_wr_data_r <= 8'h00;
            up_valid_r   <= 1'b0;
            up_data_r    <= 8'h00;
            hv_end_r     <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= CODE_NONE;
            rsp_len_r    <= CNT_ZERO;
        end else begin
            cnt_r        <= cnt_nxt_s;
            timer_r      <= timer_nxt_s;
            hv_wr_en_r   <= hv_wr_en_nxt_s;
            hv_wr_data_r <= hv_wr_data_nxt_s;
            up_valid_r   <= up_valid_nxt_s;
            up_data_r    <= up_data_nxt_s;
            hv_end_r     <= hv_end_nxt_s;
            err_r        <= err_nxt_s;
            err_code_r   <= err_code_nxt_s;
            rsp_len_r    <= rsp_len_nxt_s;
        end
    end

    assign cmd_ready  = cmd_ready_s;
    assign hv_busy    = (state_r != ST_IDLE);
    assign hv_wr_en   = hv_wr_en_r;
    assign hv_wr_data = hv_wr_data_r;
    assign up_valid   = up_valid_r;
    assign up_data    = up_data_r;
    assign hv_end     = hv_end_r;
    assign err        = err_r;
    assign err_code   = err_code_r;
    assign rsp_len    = rsp_len_r;

endmodule

// File: tb/tb_hv_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hv_transaction_ctrl
//
// Directed bench for hv_transaction_ctrl with a short reply timeout. Inputs
// change 1 ns after the rising edge; outputs are checked at that point or
// captured by a falling-edge monitor that logs every tx and upstream byte.
// -----------------------------------------------------------------------------
module tb_hv_transaction_ctrl;

    localparam int MAX_FRAME      = 32;
    localparam int CNT_W          = 6;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int TO_W           = 7;

    logic             clk;
    logic             rst_n;
    logic             soft_rst;
    logic             hv_start;
    logic [7:0]       cmd_data;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             hv_wr_en;
    logic [7:0]       hv_wr_data;
    logic [7:0]       hv_rd_data;
    logic             hv_rd_valid;
    logic [7:0]       up_data;
    logic             up_valid;
    logic             hv_busy;
    logic             hv_end;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] rsp_len;

    int checks_r   = 0;
    int failures_r = 0;

    int wr_cnt_r  = 0;
    int up_cnt_r  = 0;
    int end_cnt_r = 0;
    logic [7:0] wr_log_r [256];
    logic [7:0] up_log_r [256];

    int wr_base_s;
    int up_base_s;
    int end_base_s;

    logic [7:0] cmd_frame_s [4];
    logic [7:0] ok_frame_s  [4];
    logic [7:0] t5_frame_s  [5];

    hv_transaction_ctrl #(
        .MAX_FRAME      (MAX_FRAME),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst    (soft_rst),
        .hv_start    (hv_start),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .hv_wr_en    (hv_wr_en),
        .hv_wr_data  (hv_wr_data),
        .hv_rd_data  (hv_rd_data),
        .hv_rd_valid (hv_rd_valid),
        .up_data     (up_data),
        .up_valid    (up_valid),
        .hv_busy     (hv_busy),
        .hv_end      (hv_end),
        .err         (err),
        .err_code    (err_code),
        .rsp_len     (rsp_len)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Falling-edge monitor: log every strobe from the DUT.
    always @(negedge clk) begin
        if (hv_wr_en) begin
            wr_log_r[wr_cnt_r % 256] <= hv_wr_data;
            wr_cnt_r <= wr_cnt_r + 1;
        end
        if (up_valid) begin
            up_log_r[up_cnt_r % 256] <= up_data;
            up_cnt_r <= up_cnt_r + 1;
        end
        if (hv_end) begin
            end_cnt_r <= end_cnt_r + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (act !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        wr_base_s  = wr_cnt_r;
        up_base_s  = up_cnt_r;
        end_base_s = end_cnt_r;
    endtask

    task automatic start_txn();
        hv_start = 1'b1;
        tick();
        hv_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        hv_rd_valid = 1'b1;
        hv_rd_data  = b;
        tick();
        hv_rd_valid = 1'b0;
    endtask

    task automatic send_cmd();
        for (int i = 0; i < 4; i++) begin
            send_byte(cmd_frame_s[i]);
        end
    endtask

    // Complete successful exchange: 02 V S 0D out, 02 O K 0D back.
    task automatic run_t1(input string tag);
        snap();
        start_txn();
        check_eq({tag, "_busy"}, {31'd0, hv_busy}, 32'd1);
        check_eq({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        send_cmd();
        check_eq({tag, "_ready_wait"}, {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rx_byte(ok_frame_s[i]);
        end
        check_eq({tag, "_end"}, {31'd0, hv_end}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
        check_eq({tag, "_rsp_len"}, 32'(rsp_len), 32'd4);
        tick();
        check_eq({tag, "_busy_fall"}, {31'd0, hv_busy}, 32'd0);
        check_eq({tag, "_end_fall"}, {31'd0, hv_end}, 32'd0);
        check_eq({tag, "_wr_cnt"}, 32'(wr_cnt_r - wr_base_s), 32'd4);
        check_eq({tag, "_up_cnt"}, 32'(up_cnt_r - up_base_s), 32'd4);
        check_eq({tag, "_end_cnt"}, 32'(end_cnt_r - end_base_s), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq({tag, "_wr_byte"}, {24'd0, wr_log_r[(wr_base_s + i) % 256]}, {24'd0, cmd_frame_s[i]});
            check_eq({tag, "_up_byte"}, {24'd0, up_log_r[(up_base_s + i) % 256]}, {24'd0, ok_frame_s[i]});
        end
    endtask

    initial begin
        cmd_frame_s = '{8'h02, 8'h56, 8'h53, 8'h0D};
        ok_frame_s  = '{8'h02, 8'h4F, 8'h4B, 8'h0D};
        t5_frame_s  = '{8'h02, 8'h4F, 8'h4B, 8'h21, 8'h0D};

        rst_n       = 1'b0;
        soft_rst    = 1'b0;
        hv_start    = 1'b0;
        cmd_data    = 8'h00;
        cmd_valid   = 1'b0;
        hv_rd_data  = 8'h00;
        hv_rd_valid = 1'b0;
        tick();
        tick();

        // Reset state.
        check_eq("rst_busy", {31'd0, hv_busy}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_wr_en", {31'd0, hv_wr_en}, 32'd0);
        check_eq("rst_up_valid", {31'd0, up_valid}, 32'd0);
        check_eq("rst_end", {31'd0, hv_end}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_code", {30'd0, err_code}, 32'd0);
        check_eq("rst_rsp_len", 32'(rsp_len), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: normal transaction.
        run_t1("t1");

        // T2: bad first command byte.
        snap();
        start_txn();
        send_byte(8'h41);
        check_eq("t2_end", {31'd0, hv_end}, 32'd1);
        check_eq("t2_err", {31'd0, err}, 32'd1);
        check_eq("t2_code", {30'd0, err_code}, 32'd1);
        tick();
        check_eq("t2_wr_cnt", 32'(wr_cnt_r - wr_base_s), 32'd0);
        check_eq("t2_busy", {31'd0, hv_busy}, 32'd0);

        // T3: reply timeout, 100 cycles after entering WAIT_RSP.
        snap();
        start_txn();
        check_eq("t3_err_cleared", {31'd0, err}, 32'd0);
        send_cmd();
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            tick();
        end
        check_eq("t3_end_early", {31'd0, hv_end}, 32'd0);
        check_eq("t3_busy_wait", {31'd0, hv_busy}, 32'd1);
        tick();
        check_eq("t3_end", {31'd0, hv_end}, 32'd1);
        check_eq("t3_err", {31'd0, err}, 32'd1);
        check_eq("t3_code", {30'd0, err_code}, 32'd3);
        tick();

        // T4: reply of STX plus 40 bytes without CR.
        snap();
        start_txn();
        send_cmd();
        rx_byte(8'h02);
        for (int i = 0; i < 40; i++) begin
            rx_byte(8'h30 + 8'(i));
        end
        tick();
        check_eq("t4_up_cnt", 32'(up_cnt_r - up_base_s), 32'd32);
        check_eq("t4_end_cnt", 32'(end_cnt_r - end_base_s), 32'd1);
        check_eq("t4_err", {31'd0, err}, 32'd1);
        check_eq("t4_code", {30'd0, err_code}, 32'd2);
        check_eq("t4_last_up", {24'd0, up_log_r[(up_base_s + 31) % 256]}, 32'h4E);

        // T5: noise before the reply is dropped.
        snap();
        start_txn();
        send_cmd();
        rx_byte(8'h55);
        rx_byte(8'h0D);
        for (int i = 0; i < 5; i++) begin
            rx_byte(t5_frame_s[i]);
        end
        check_eq("t5_end", {31'd0, hv_end}, 32'd1);
        check_eq("t5_err", {31'd0, err}, 32'd0);
        check_eq("t5_code", {30'd0, err_code}, 32'd0);
        check_eq("t5_rsp_len", 32'(rsp_len), 32'd5);
        tick();
        check_eq("t5_up_cnt", 32'(up_cnt_r - up_base_s), 32'd5);
        check_eq("t5_first_up", {24'd0, up_log_r[up_base_s % 256]}, 32'h02);

        // T6: soft_rst with hv_start in the same cycle, mid-RECV.
        snap();
        start_txn();
        send_cmd();
        rx_byte(8'h02);
        rx_byte(8'h4F);
        soft_rst = 1'b1;
        hv_start = 1'b1;
        tick();
        soft_rst = 1'b0;
        hv_start = 1'b0;
        check_eq("t6_busy", {31'd0, hv_busy}, 32'd0);
        check_eq("t6_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("t6_end", {31'd0, hv_end}, 32'd0);
        check_eq("t6_rsp_len", 32'(rsp_len), 32'd0);
        tick();
        tick();
        check_eq("t6_busy_hold", {31'd0, hv_busy}, 32'd0);
        check_eq("t6_end_cnt", 32'(end_cnt_r - end_base_s), 32'd0);
        run_t1("t6b");

        // T7: command of MAX_FRAME bytes without CR overflows on the tx side.
        snap();
        start_txn();
        send_byte(8'h02);
        for (int i = 0; i < MAX_FRAME - 1; i++) begin
            send_byte(8'h41 + 8'(i % 16));
        end
        check_eq("t7_end", {31'd0, hv_end}, 32'd1);
        check_eq("t7_code", {30'd0, err_code}, 32'd2);
        check_eq("t7_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        check_eq("t7_wr_cnt", 32'(wr_cnt_r - wr_base_s), 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
